// File: rtl/ins_cache_pkg.sv
// ins_cache_pkg: state codes shared by the instruction cache
// and the program counter that polls it.
package ins_cache_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      LOAD_INS = 4'd1,
      LOAD_END = 4'd2,
      SENT_INS = 4'd3,
      MISS     = 4'd4
   } ic_state_e;

   // The program counter waits for this code before fetching.
   localparam logic [3:0] ST_SENT_INS = 4'd3;

endpackage

// File: rtl/ins_cache_ram.sv
// ins_cache_ram: single-port block store with a registered,
// enable-held read port.
module ins_cache_ram #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 32,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic             re_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rdata_q <= '0;
      else if (re_i && !we_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ins_cache_ctrl.sv
// ins_cache_ctrl: one-block instruction cache filled from DDR
// on demand, serving the program counter fetch port.
module ins_cache_ctrl
   import ins_cache_pkg::*;
#(
   parameter int ADDR_WIDTH_MEM  = 16,
   parameter int ISA_DEPTH       = 64,
   parameter int TOTAL_ISA_DEPTH = 128,
   parameter int DDR_ADDR_WIDTH  = 28,
   parameter int ISA_WIDTH       = 32,
   parameter int ISA_BASE_DDR    = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
   output logic [ISA_WIDTH-1:0]      instruction,
   output logic                      ins_cache_rdy,
   output logic [3:0]                st_cur_ins_cache,
   output logic [9:0]                load_times,
   output logic                      ddr_rd_en,
   output logic [DDR_ADDR_WIDTH-1:0] ddr_addr,
   input  logic                      ddr_data_valid,
   input  logic [ISA_WIDTH-1:0]      ddr_data
);

   localparam int LOG2 = $clog2(ISA_DEPTH);
   localparam int FW   = LOG2 + 1;
   localparam int WW   = ADDR_WIDTH_MEM + 10;

   ic_state_e                 state_q;
   logic [ADDR_WIDTH_MEM-1:0] block_base_q;
   logic [FW-1:0]             fill_cnt_q;
   logic [9:0]                load_times_q;
   logic                      rd_en_q;
   logic                      rdy_q;
   logic [DDR_ADDR_WIDTH-1:0] ddr_addr_q;
   logic [DDR_ADDR_WIDTH-1:0] ddr_addr_d;

   logic [WW-1:0]   addr_w;
   logic [WW-1:0]   win_hi;
   logic [WW-1:0]   win_lo;
   logic [WW-1:0]   fill_pos;
   logic            in_range;
   logic            hit;
   logic            fill_done;
   logic            ram_we;
   logic            ram_re;
   logic [LOG2-1:0] ram_addr;

   assign addr_w    = WW'(addr_ins);
   assign win_hi    = WW'(load_times_q) << LOG2;
   assign win_lo    = win_hi - WW'(ISA_DEPTH);
   assign in_range  = addr_w < WW'(TOTAL_ISA_DEPTH);
   assign hit       = in_range && (addr_w >= win_lo)
                      && (addr_w < win_hi);
   assign fill_pos  = WW'(block_base_q) + WW'(fill_cnt_q);
   // A short last block stops at the end of the program.
   assign fill_done = (fill_cnt_q == FW'(ISA_DEPTH))
                      || (fill_pos >= WW'(TOTAL_ISA_DEPTH));
   assign ddr_addr_d = DDR_ADDR_WIDTH'(ISA_BASE_DDR)
                       + DDR_ADDR_WIDTH'({fill_pos, 3'b000});

   assign ram_we   = (state_q == LOAD_INS) && rd_en_q
                     && ddr_data_valid && !fill_done;
   assign ram_re   = (state_q == SENT_INS) && hit;
   assign ram_addr = ram_we ? fill_cnt_q[LOG2-1:0]
                            : addr_ins[LOG2-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         block_base_q <= '0;
         fill_cnt_q   <= '0;
         load_times_q <= '0;
         rd_en_q      <= 1'b0;
         rdy_q        <= 1'b0;
         ddr_addr_q   <= '0;
      end else begin
         rdy_q <= 1'b0;
         case (state_q)
            IDLE: begin
               block_base_q <= '0;
               fill_cnt_q   <= '0;
               state_q      <= LOAD_INS;
            end
            LOAD_INS: begin
               if (fill_done) begin
                  rd_en_q <= 1'b0;
                  state_q <= LOAD_END;
               end else if (rd_en_q) begin
                  if (ddr_data_valid) begin
                     rd_en_q    <= 1'b0;
                     fill_cnt_q <= fill_cnt_q + FW'(1);
                  end
               end else begin
                  rd_en_q    <= 1'b1;
                  ddr_addr_q <= ddr_addr_d;
               end
            end
            LOAD_END: begin
               load_times_q <= 10'(block_base_q >> LOG2) + 10'd1;
               state_q      <= SENT_INS;
            end
            SENT_INS: begin
               if (hit) rdy_q <= 1'b1;
               else if (in_range) state_q <= MISS;
            end
            MISS: begin
               block_base_q <= addr_ins
                               & ~ADDR_WIDTH_MEM'(ISA_DEPTH - 1);
               fill_cnt_q   <= '0;
               state_q      <= LOAD_INS;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   ins_cache_ram #(
      .DEPTH (ISA_DEPTH),
      .WIDTH (ISA_WIDTH),
      .AW    (LOG2)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (ddr_data),
      .rdata_o (instruction)
   );

   assign ins_cache_rdy    = rdy_q;
   assign st_cur_ins_cache = state_q;
   assign load_times       = load_times_q;
   assign ddr_rd_en        = rd_en_q;
   assign ddr_addr         = ddr_addr_q;

endmodule
